// File: rtl/count_snapshot_ctrl.sv
//------------------------------------------------------------------------------
// Module  : count_snapshot_ctrl
// Brief   : Free-running WIDTH-bit event counter with coherent snapshot capture
//           and nibble-serial readout over a valid/ready handshake.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module count_snapshot_ctrl #(
    parameter int WIDTH = 256,
    parameter int NIBS  = WIDTH / 4,
    parameter int IW    = $clog2(NIBS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          run,
    input  logic          clr,
    input  logic          snap_req,
    input  logic          abort,
    output logic          snap_busy,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [3:0]    out_nib,
    output logic [IW-1:0] out_idx,
    output logic          out_last,
    output logic          wrapped,
    output logic [3:0]    cnt_lo
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    localparam logic [IW-1:0]    C_LAST_IDX = IW'(NIBS - 1);
    localparam logic [WIDTH-1:0] C_ALL_ONES = '1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_shadow;
    logic             r_wrapped;
    logic [IW-1:0]    r_idx;
    logic [IW-1:0]    w_idx_nxt;
    logic             w_capture;
    logic             w_streaming;
    logic [IW+1:0]    w_bitpos;

    // The counter is never stalled by the readout path; only shadow is read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_wrapped <= 1'b0;
        end else if (clr) begin
            r_cnt     <= '0;
            r_wrapped <= 1'b0;
        end else if (run) begin
            r_cnt <= r_cnt + WIDTH'(1);
            if (r_cnt == C_ALL_ONES) begin
                r_wrapped <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_idx    <= '0;
            r_shadow <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            if (w_capture) begin
                r_shadow <= r_cnt;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (snap_req) begin
                    w_capture   = 1'b1;
                    w_idx_nxt   = C_LAST_IDX;
                    w_state_nxt = ST_STREAM;
                end
            end
            ST_STREAM: begin
                // Abort takes precedence; a coincident handshake is discarded.
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (out_ready) begin
                    if (r_idx == '0) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_idx_nxt = r_idx - IW'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_streaming = (r_state == ST_STREAM);
    assign w_bitpos    = {r_idx, 2'b00};

    assign snap_busy = w_streaming;
    assign out_valid = w_streaming;
    assign out_nib   = w_streaming ? r_shadow[w_bitpos +: 4] : 4'h0;
    assign out_idx   = w_streaming ? r_idx : '0;
    assign out_last  = w_streaming && (r_idx == '0);
    assign wrapped   = r_wrapped;
    assign cnt_lo    = r_cnt[3:0];

endmodule

`default_nettype wire

// File: tb/tb_count_snapshot_ctrl.sv
//------------------------------------------------------------------------------
// Module  : tb_count_snapshot_ctrl
// Brief   : Self-checking bench for count_snapshot_ctrl at WIDTH=8 and WIDTH=256
//           against a behavioural counter/snapshot model.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_count_snapshot_ctrl;

    logic clk;
    logic rst_n;

    // Index 0 drives the WIDTH=8 instance, index 1 the WIDTH=256 instance.
    logic [1:0] run, clr, snap_req, abort, out_ready;
    logic [1:0] snap_busy, out_valid, out_last, wrapped;
    logic [3:0] nib0, nib1, lo0, lo1;
    logic [0:0] idx0;
    logic [5:0] idx1;

    int n_cmp;
    int n_err;

    count_snapshot_ctrl #(.WIDTH(8)) u_dut_n (
        .clk(clk), .rst_n(rst_n), .run(run[0]), .clr(clr[0]),
        .snap_req(snap_req[0]), .abort(abort[0]), .snap_busy(snap_busy[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_nib(nib0),
        .out_idx(idx0), .out_last(out_last[0]), .wrapped(wrapped[0]), .cnt_lo(lo0)
    );

    count_snapshot_ctrl #(.WIDTH(256)) u_dut_w (
        .clk(clk), .rst_n(rst_n), .run(run[1]), .clr(clr[1]),
        .snap_req(snap_req[1]), .abort(abort[1]), .snap_busy(snap_busy[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_nib(nib1),
        .out_idx(idx1), .out_last(out_last[1]), .wrapped(wrapped[1]), .cnt_lo(lo1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: counter value, sticky wrap, captured snapshot and the
    // position of the next nibble still to be delivered.
    int            m_w   [2];
    logic [255:0]  m_cnt [2];
    logic [255:0]  m_snap[2];
    bit            m_wrap[2];
    bit            m_busy[2];
    int            m_pos [2];

    initial begin
        logic [255:0] mask;
        m_w[0] = 8;
        m_w[1] = 256;
        forever begin
            @(posedge clk or negedge rst_n);
            for (int k = 0; k < 2; k++) begin
                if (!rst_n) begin
                    m_cnt[k]  = '0;
                    m_snap[k] = '0;
                    m_wrap[k] = 1'b0;
                    m_busy[k] = 1'b0;
                    m_pos[k]  = 0;
                end else begin
                    mask = {256{1'b1}} >> (256 - m_w[k]);
                    if (m_busy[k]) begin
                        if (abort[k]) begin
                            m_busy[k] = 1'b0;
                        end else if (out_ready[k]) begin
                            if (m_pos[k] == 0) m_busy[k] = 1'b0;
                            else               m_pos[k]  = m_pos[k] - 1;
                        end
                    end else if (snap_req[k]) begin
                        m_snap[k] = m_cnt[k];
                        m_pos[k]  = m_w[k] / 4 - 1;
                        m_busy[k] = 1'b1;
                    end
                    if (clr[k]) begin
                        m_cnt[k]  = '0;
                        m_wrap[k] = 1'b0;
                    end else if (run[k]) begin
                        if (m_cnt[k] == mask) m_wrap[k] = 1'b1;
                        m_cnt[k] = (m_cnt[k] + 256'd1) & mask;
                    end
                end
            end
        end
    end

    // Every output of both instances against the model, mid-cycle.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic [255:0] e_nib;
            e_nib = m_busy[k] ? ((m_snap[k] >> (4 * m_pos[k])) & 256'hF) : '0;
            chk($sformatf("busy[%0d]", k),  snap_busy[k], m_busy[k]);
            chk($sformatf("valid[%0d]", k), out_valid[k], m_busy[k]);
            chk($sformatf("last[%0d]", k),  out_last[k],  m_busy[k] && m_pos[k] == 0);
            chk($sformatf("wrap[%0d]", k),  wrapped[k],   m_wrap[k]);
            chk($sformatf("nib[%0d]", k),   (k == 0) ? nib0 : nib1, e_nib);
            chk($sformatf("idx[%0d]", k),   (k == 0) ? 6'(idx0) : idx1,
                m_busy[k] ? 256'(m_pos[k]) : '0);
            chk($sformatf("cnt_lo[%0d]", k), (k == 0) ? lo0 : lo1, m_cnt[k] & 256'hF);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic quiet();
        run = '0; clr = '0; snap_req = '0; abort = '0; out_ready = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        quiet();
        rst_n = 1'b0;
        #1;
        chk("reset_valid", out_valid, 2'b00);
        chk("reset_lo", {lo1, lo0}, 8'h00);
        do_reset();

        // 256-bit instance: count 10, snapshot, stream 64 nibbles.
        run[1] = 1'b1;
        repeat (10) tick();
        run[1] = 1'b0;
        snap_req[1] = 1'b1;
        out_ready[1] = 1'b1;
        tick();
        snap_req[1] = 1'b0;
        chk("first_idx", idx1, 6'd63);
        chk("first_nib", nib1, 4'h0);
        repeat (62) tick();
        chk("idx1_nib", {idx1, nib1}, {6'd1, 4'h0});
        tick();
        chk("idx0_nib", {idx1, nib1, out_last[1]}, {6'd0, 4'hA, 1'b1});
        tick();
        chk("busy_after_last", snap_busy[1], 1'b0);
        quiet();

        // 8-bit instance: backpressure with cnt=0xC5.
        do_reset();
        run[0] = 1'b1;
        repeat (197) tick();
        snap_req[0] = 1'b1;
        out_ready[0] = 1'b1;
        tick();
        snap_req[0] = 1'b0;
        out_ready[0] = 1'b0;
        chk("bp_nib_c", {idx0, nib0}, {1'b1, 4'hC});
        chk("bp_lo", lo0, 4'h6);
        tick();
        tick();
        chk("bp_hold", {idx0, nib0}, {1'b1, 4'hC});
        out_ready[0] = 1'b1;
        tick();
        chk("bp_nib_5", {idx0, nib0, out_last[0]}, {1'b0, 4'h5, 1'b1});
        tick();
        quiet();

        // Wrap, clear, and clear-over-run.
        do_reset();
        run[0] = 1'b1;
        repeat (256) tick();
        chk("wrap_set", {wrapped[0], lo0}, {1'b1, 4'h0});
        clr[0] = 1'b1;
        run[0] = 1'b0;
        tick();
        chk("wrap_clr", wrapped[0], 1'b0);
        run[0] = 1'b1;
        tick();
        chk("clr_over_run", lo0, 4'h0);
        clr[0] = 1'b0;

        // Abort in the second stream cycle, then recapture.
        repeat (5) tick();
        snap_req[0] = 1'b1;
        tick();
        snap_req[0] = 1'b0;
        tick();
        abort[0] = 1'b1;
        tick();
        abort[0] = 1'b0;
        chk("abort_idle", {out_valid[0], snap_busy[0]}, 2'b00);
        snap_req[0] = 1'b1;
        abort[0] = 1'b1;
        tick();
        abort[0] = 1'b0;
        snap_req[0] = 1'b0;
        chk("recapture", snap_busy[0], 1'b1);
        tick();
        tick();

        // snap_req held high with ready high: capture, 2 transfers, gap.
        out_ready[0] = 1'b1;
        snap_req[0] = 1'b1;
        repeat (12) tick();
        quiet();
        tick();

        // Randomized traffic on both instances.
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 2; k++) begin
                run[k]       = ($urandom_range(0, 3) != 0);
                clr[k]       = ($urandom_range(0, 63) == 0);
                snap_req[k]  = ($urandom_range(0, 3) == 0);
                abort[k]     = ($urandom_range(0, 31) == 0);
                out_ready[k] = ($urandom_range(0, 2) != 0);
            end
            tick();
        end

        // Reset mid-stream clears outputs without a clock edge.
        quiet();
        tick();
        run = 2'b11;
        snap_req = 2'b11;
        tick();
        snap_req = 2'b00;
        chk("pre_rst_busy", snap_busy, 2'b11);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst", {snap_busy, out_valid, out_last, wrapped, nib0, nib1, lo0, lo1,
                          7'(idx0), idx1}, '0);
        quiet();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst", {snap_busy, lo0, lo1}, '0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/count_snapshot_ctrl.md
# count_snapshot_ctrl

Controller for the wide free-running event counter in the TinyTapeout top level. It owns the WIDTH-bit counter and its run/clear sequencing. On request it takes a coherent snapshot of the counter into a shadow register, then streams that snapshot out one nibble per handshake on the 4-bit output lanes. The full counter value becomes observable through narrow pins without stopping the count.

## Interface

Parameters:
- WIDTH, 256: counter and shadow width in bits; multiple of 4, minimum 8.
- NIBS, WIDTH/4: number of nibbles per snapshot (derived, do not override).
- IW, $clog2(NIBS): nibble-index width (derived).

Ports:
- clk  in  1  system clock, 25.175 MHz nominal, 25.000 MHz acceptable.
- rst_n  in  1  reset, asynchronous assert, active-low.
- run  in  1  level; counter increments by 1 on each clk edge while high.
- clr  in  1  synchronous clear of counter and wrap flag; overrides run.
- snap_req  in  1  snapshot request; sampled only in IDLE.
- abort  in  1  synchronous abort of an in-progress stream.
- snap_busy  out  1  high from the capture edge until the stream completes or aborts.
- out_valid  out  1  out_nib/out_idx/out_last are valid.
- out_ready  in  1  consumer accepts the current nibble.
- out_nib  out  4  current snapshot nibble.
- out_idx  out  IW  index of out_nib; NIBS-1 = most significant.
- out_last  out  1  high with out_valid on nibble 0.
- wrapped  out  1  sticky; set when the counter rolls over from all-ones to 0.
- cnt_lo  out  4  live counter bits [3:0], for pin monitoring.

## Operation

- Reset (rst_n=0, asynchronous): cnt=0, shadow=0, wrapped=0, state=IDLE. All outputs are 0.
- Counter update per edge, in priority order:
  - clr=1 → cnt=0, wrapped=0.
  - else run=1 → cnt=cnt+1, modulo 2^WIDTH.
  - else hold.
- Wrap flag: when cnt=all-ones and it increments, cnt becomes 0 and wrapped=1. wrapped stays set until clr or reset.
- The counter never stalls for readout. Streaming only reads shadow.
- FSM states: IDLE, STREAM.
- IDLE:
  - snap_req=1 → shadow ← cnt value present before this edge (the pre-increment value).
  - On the same edge: idx ← NIBS-1, state → STREAM.
  - snap_req=0 → stay in IDLE.
- STREAM:
  - out_valid=1.
  - out_nib = shadow[4*idx+3 : 4*idx].
  - out_idx = idx.
  - out_last = (idx==0).
  - Transfer occurs when out_valid and out_ready are both high.
  - On a transfer with idx>0 → idx ← idx-1.
  - On a transfer with idx==0 → state → IDLE.
  - snap_req is ignored in STREAM.
- abort=1 in STREAM → state → IDLE at the next edge. Abort wins over a simultaneous transfer; that nibble is counted as not delivered.
- abort in IDLE has no effect. abort and snap_req together in IDLE → the capture occurs (abort is ignored).
- clr or run during STREAM changes cnt only. shadow and the stream are unaffected.
- In IDLE: out_nib, out_idx and out_last are 0.

## Timing

- snap_busy = (state==STREAM); it is a registered output.
- out_valid rises on the edge that samples snap_req. The first nibble (idx NIBS-1) is therefore valid one cycle after snap_req is presented.
- With out_ready held high, a full stream takes exactly NIBS cycles. out_valid falls on the edge after the out_last transfer.
- When out_ready is low, out_nib, out_idx and out_last hold stable.
- A snap_req in the cycle of the last transfer is ignored (state is still STREAM). The earliest new capture is the following cycle, so back-to-back snapshots have a 1-cycle IDLE gap.
- cnt_lo and wrapped are registered and reflect cnt/flag after the most recent edge.
- Reset mid-stream: all outputs return to 0 asynchronously. No partial stream resumes after reset.

## Test plan

- Reset, then run=1 for 10 cycles, then snap_req pulse with out_ready=1:
  - captured value = 10.
  - 64 nibbles stream at idx 63…0.
  - the first 62 nibbles are 0; idx 1 → 0x0; idx 0 → 0xA.
  - out_last only on idx 0; snap_busy low on the following cycle.
- Backpressure, with WIDTH=8 and cnt=0xC5, out_ready toggled 1,0,0,1:
  - nibble 0xC is held for the stall cycles, then 0x5 is delivered.
  - the counter keeps running throughout, seen on cnt_lo.
- Wrap, with WIDTH=8 and run held for 256 cycles:
  - cnt returns to 0 and wrapped=1.
  - clr pulse → wrapped=0, cnt=0.
  - clr and run high together → cnt stays 0.
- Abort, with WIDTH=8 and out_ready=0:
  - abort in the 2nd STREAM cycle → out_valid=0 and snap_busy=0 the next cycle.
  - a new snap_req then captures the current cnt.
- snap_req held high continuously, WIDTH=8, out_ready=1:
  - pattern is capture, 2 transfers, 1 idle cycle, capture, repeating.
  - each capture equals cnt at its capture edge.
- rst_n asserted mid-stream:
  - all outputs go to 0 immediately, without a clock edge.
  - after release: state IDLE, cnt=0.
